vga_pixel_arbiter: RTL and testbench
====================================

VGA_PIXEL_ARBITER -- requirements
Module: vga_pixel_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, pixel memory address width.
REQ-002 Parameter DATA_W, default 12, pixel word width (RGB 4:4:4).
REQ-003 Parameter STARVE_MAX, default 800, host wait cycles before the starve flag sets.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 disp_req  in  1  display needs a pixel fetch this cycle (active video).
REQ-007 disp_addr  in  ADDR_W  display fetch address.
REQ-008 disp_valid  out  1  disp_data valid (registered).
REQ-009 disp_data  out  DATA_W  fetched display pixel.
REQ-010 host_valid  in  1  host request present.
REQ-011 host_ready  out  1  arbiter accepts a host request.
REQ-012 host_we  in  1  1 = write, 0 = read.
REQ-013 host_addr  in  ADDR_W  host address.
REQ-014 host_wdata  in  DATA_W  host write data.
REQ-015 host_rvalid  out  1  host read data valid, one-cycle pulse.
REQ-016 host_rdata  out  DATA_W  host read data.
REQ-017 mem_en, mem_we  out  1 each  single-port RAM enable and write strobe.
REQ-018 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  RAM address and write data.
REQ-019 mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read enable.
REQ-020 starve  out  1  sticky flag: host waited STARVE_MAX cycles.
REQ-021 host_ops  out  16  count of completed host operations.

Function
REQ-022 mem_en/mem_we/mem_addr/mem_wdata SHALL be combinational from disp_req, disp_addr and arbiter state.
REQ-023 disp_req high SHALL always win: mem_en=1, mem_we=0, mem_addr=disp_addr, regardless of pending host work.
REQ-024 A display read issued in cycle N SHALL give disp_valid=1 and disp_data=mem_rdata in cycle N+1; disp_valid=0 otherwise.
REQ-025 FSM states IDLE, PEND, RDWAIT; host_ready SHALL be 1 only in IDLE.
REQ-026 IDLE: host_valid&host_ready SHALL latch host_we/host_addr/host_wdata into a hold register and go to PEND; no memory access in the accept cycle.
REQ-027 PEND with disp_req=1: stay in PEND, no host access, wait counter increments (saturating at STARVE_MAX).
REQ-028 PEND with disp_req=0: issue held op (mem_en=1, mem_we=held we, mem_addr/mem_wdata from hold); write -> IDLE, read -> RDWAIT.
REQ-029 RDWAIT: host_rvalid=1 for exactly this cycle, host_rdata=mem_rdata, -> IDLE; mem_en SHALL follow disp_req only.
REQ-030 host_rdata SHALL hold its last value when host_rvalid=0.
REQ-031 Wait counter SHALL clear on each accept; when it reaches STARVE_MAX, starve SHALL set and stay set until reset.
REQ-032 host_ops SHALL increment by 1 on each write issue and each RDWAIT cycle; wraps 0xFFFF -> 0x0000.
REQ-033 Minimum host latency: write accept N, issue N+1; read accept N, issue N+1, rvalid N+2.
REQ-034 The cycle after RDWAIT or a write issue is IDLE, so back-to-back host ops SHALL cost at least 2 cycles (write) or 3 cycles (read) each.
REQ-035 The arbiter SHALL never drive a host and a display access in the same cycle.

Reset
REQ-036 While rst=0: state IDLE, host_ready=1, disp_valid=0, host_rvalid=0, host_rdata=0, disp_data=0, starve=0, host_ops=0, wait counter=0, hold register=0.
REQ-037 Reset mid-operation SHALL drop any pending or in-flight host op with no host_rvalid pulse and no memory write after rst deasserts.

Verification
REQ-038 disp_req=1 continuous, addr 0..7, RAM preloaded data=addr -> disp_valid=1 each following cycle, disp_data=0..7 with one-cycle lag.
REQ-039 disp_req=0, host write addr 0x010 data 0xABC, then read 0x010 -> write issued cycle after accept, host_rvalid two cycles after read accept with 0xABC; host_ops=2.
REQ-040 Host read accepted while disp_req=1 for 20 cycles -> no host mem access for 20 cycles, issue on first disp_req=0 cycle, correct data, starve=0.
REQ-041 STARVE_MAX=8, host write pending, disp_req=1 for 10 cycles -> starve=1 after 8 waiting cycles, stays 1 after write completes.
REQ-042 Host read in RDWAIT, rst pulsed low -> no host_rvalid, host_ready=1, host_ops=0 after release.
REQ-043 host_ops preset by 65535 writes, one more write -> host_ops=0x0000.

Source files
------------

// File: rtl/vga_pixel_arbiter.sv
// Pixel RAM arbiter: display fetch always wins the single port,
// host ops are held and issued in the first display-free cycle.
module vga_pixel_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 12,
  parameter int STARVE_MAX = 800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              starve,
  output logic [15:0]       host_ops
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    RDWAIT
  } state_t;

  state_t            state;
  logic              hold_we;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_wdata;
  logic [CW-1:0]     wait_cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              host_issue;
  logic              ops_inc;

  assign host_ready  = (state == IDLE);
  assign host_rvalid = (state == RDWAIT);
  assign host_issue  = (state == PEND) & ~disp_req;
  assign ops_inc     = (host_issue & hold_we) | host_rvalid;

  assign mem_en    = disp_req | host_issue;
  assign mem_we    = host_issue & hold_we;
  assign mem_addr  = disp_req ? disp_addr : hold_addr;
  assign mem_wdata = hold_wdata;

  assign disp_data  = disp_valid ? mem_rdata : '0;
  assign host_rdata = host_rvalid ? mem_rdata : rdata_q;

  // display read returns data the cycle after it is issued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_valid <= 1'b0;
    end else begin
      disp_valid <= disp_req;
    end
  end

  // host FSM: accept, wait out display traffic, issue, return read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      wait_cnt   <= '0;
      rdata_q    <= '0;
      starve     <= 1'b0;
      host_ops   <= '0;
    end else begin
      if (ops_inc) begin
        host_ops <= host_ops + 16'd1;
      end
      unique case (state)
        IDLE: begin
          if (host_valid) begin
            hold_we    <= host_we;
            hold_addr  <= host_addr;
            hold_wdata <= host_wdata;
            wait_cnt   <= '0;
            state      <= PEND;
          end
        end
        PEND: begin
          if (disp_req) begin
            if (wait_cnt != SMAX) begin
              wait_cnt <= wait_cnt + 1'b1;
              if (wait_cnt + 1'b1 == SMAX) begin
                starve <= 1'b1;
              end
            end
          end else begin
            state <= hold_we ? IDLE : RDWAIT;
          end
        end
        RDWAIT: begin
          rdata_q <= mem_rdata;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_pixel_arbiter.sv
// Scoreboard bench for vga_pixel_arbiter: directed vectors,
// expected read data queued at issue, popped by a monitor.
module tb_vga_pixel_arbiter;

  localparam int AW = 12;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          host_valid;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] mem_rdata;

  logic          disp_valid, host_ready, host_rvalid;
  logic [DW-1:0] disp_data, host_rdata;
  logic          mem_en, mem_we, starve;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [15:0]   host_ops;

  logic          s_disp_valid, s_host_ready, s_host_rvalid;
  logic [DW-1:0] s_disp_data, s_host_rdata;
  logic          s_mem_en, s_mem_we, s_starve;
  logic [AW-1:0] s_mem_addr;
  logic [DW-1:0] s_mem_wdata;
  logic [15:0]   s_host_ops;

  logic [DW-1:0] ram [0:4095];
  logic [DW-1:0] dq[$];
  logic [DW-1:0] hq[$];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_pixel_arbiter dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .starve(starve), .host_ops(host_ops)
  );

  vga_pixel_arbiter #(.STARVE_MAX(8)) dut8 (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_valid(s_disp_valid), .disp_data(s_disp_data),
    .host_valid(host_valid), .host_ready(s_host_ready),
    .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata),
    .host_rvalid(s_host_rvalid), .host_rdata(s_host_rdata),
    .mem_en(s_mem_en), .mem_we(s_mem_we),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(mem_rdata),
    .starve(s_starve), .host_ops(s_host_ops)
  );

  // single-port RAM, contents reload to data=addr during reset
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4096; i++) ram[i] <= DW'(i);
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  function automatic void chk(string nm, logic [31:0] got,
                              logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h exp %h t=%0t", nm, got, exp, $time);
    end
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (disp_valid) begin
      if (dq.size() == 0) chk("disp_unexp", 32'(disp_valid), 0);
      else chk("disp_data", 32'(disp_data), 32'(dq.pop_front()));
    end
    if (host_rvalid) begin
      if (hq.size() == 0) chk("rvalid_unexp", 32'(host_rvalid), 0);
      else chk("host_rdata", 32'(host_rdata), 32'(hq.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    n_vec++;
    n_bad++;
    $display("FAIL watchdog expired");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    rst = 1'b0;
    disp_req = 1'b0;
    disp_addr = '0;
    host_valid = 1'b0;
    host_we = 1'b0;
    host_addr = '0;
    host_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ready", 32'(host_ready), 1);
    chk("rst_dvalid", 32'(disp_valid), 0);
    chk("rst_rvalid", 32'(host_rvalid), 0);
    chk("rst_rdata", 32'(host_rdata), 0);
    chk("rst_ddata", 32'(disp_data), 0);
    chk("rst_starve", 32'(starve), 0);
    chk("rst_ops", 32'(host_ops), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    step();
    rst = 1'b1;

    // continuous display fetch 0..7
    for (int a = 0; a < 8; a++) begin
      disp_req = 1'b1;
      disp_addr = AW'(a);
      dq.push_back(DW'(a));
      @(negedge clk);
      chk("d_en", 32'(mem_en), 1);
      chk("d_we", 32'(mem_we), 0);
      chk("d_addr", 32'(mem_addr), 32'(a));
      step();
    end
    disp_req = 1'b0;
    step();
    @(negedge clk);
    chk("d_valid_off", 32'(disp_valid), 0);
    step();

    // host write 0x010=0xABC then read back
    host_valid = 1'b1;
    host_we = 1'b1;
    host_addr = 12'h010;
    host_wdata = 12'hABC;
    @(negedge clk);
    chk("w_ready", 32'(host_ready), 1);
    chk("w_acc_noen", 32'(mem_en), 0);
    step();
    host_valid = 1'b0;
    @(negedge clk);
    chk("w_en", 32'(mem_en), 1);
    chk("w_we", 32'(mem_we), 1);
    chk("w_addr", 32'(mem_addr), 32'h010);
    chk("w_data", 32'(mem_wdata), 32'hABC);
    chk("w_busy", 32'(host_ready), 0);
    step();
    host_valid = 1'b1;
    host_we = 1'b0;
    hq.push_back(12'hABC);
    @(negedge clk);
    chk("r_ready", 32'(host_ready), 1);
    chk("r_acc_noen", 32'(mem_en), 0);
    step();
    host_valid = 1'b0;
    @(negedge clk);
    chk("r_en", 32'(mem_en), 1);
    chk("r_we", 32'(mem_we), 0);
    chk("r_addr", 32'(mem_addr), 32'h010);
    chk("r_rv_early", 32'(host_rvalid), 0);
    step();
    @(negedge clk);
    chk("r_rvalid", 32'(host_rvalid), 1);
    chk("r_wait_noen", 32'(mem_en), 0);
    step();
    @(negedge clk);
    chk("r_rv_pulse", 32'(host_rvalid), 0);
    chk("r_rdata_hold", 32'(host_rdata), 32'hABC);
    chk("ops_2", 32'(host_ops), 2);
    step();

    // host read held off by 20 display cycles
    disp_req = 1'b1;
    disp_addr = 12'h100;
    dq.push_back(12'h100);
    host_valid = 1'b1;
    host_we = 1'b0;
    host_addr = 12'h010;
    hq.push_back(12'hABC);
    @(negedge clk);
    chk("h_acc_ready", 32'(host_ready), 1);
    chk("h_acc_addr", 32'(mem_addr), 32'h100);
    step();
    host_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      disp_addr = AW'(12'h100 + i);
      dq.push_back(DW'(12'h100 + i));
      @(negedge clk);
      chk("h_blk_we", 32'(mem_we), 0);
      chk("h_blk_addr", 32'(mem_addr), 32'(12'h100 + i));
      step();
    end
    disp_req = 1'b0;
    @(negedge clk);
    chk("h_iss_en", 32'(mem_en), 1);
    chk("h_iss_we", 32'(mem_we), 0);
    chk("h_iss_addr", 32'(mem_addr), 32'h010);
    step();
    @(negedge clk);
    chk("h_rvalid", 32'(host_rvalid), 1);
    step();
    @(negedge clk);
    chk("h_starve0", 32'(starve), 0);
    chk("h_starve8", 32'(s_starve), 1);
    chk("ops_3", 32'(host_ops), 3);
    step();

    // starvation with STARVE_MAX=8 on a pending write
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_starve", 32'(s_starve), 0);
    chk("rst2_ops", 32'(host_ops), 0);
    step();
    rst = 1'b1;
    disp_req = 1'b1;
    disp_addr = 12'h200;
    dq.push_back(12'h200);
    host_valid = 1'b1;
    host_we = 1'b1;
    host_addr = 12'h020;
    host_wdata = 12'h123;
    @(negedge clk);
    step();
    host_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      disp_addr = AW'(12'h200 + i);
      dq.push_back(DW'(12'h200 + i));
      @(negedge clk);
      if (i == 8) chk("s_before", 32'(s_starve), 0);
      if (i == 9) chk("s_after", 32'(s_starve), 1);
      chk("s_blk_we", 32'(mem_we), 0);
      step();
    end
    disp_req = 1'b0;
    @(negedge clk);
    chk("s_iss_we", 32'(mem_we), 1);
    chk("s_iss_addr", 32'(mem_addr), 32'h020);
    chk("s_iss_data", 32'(mem_wdata), 32'h123);
    step();
    @(negedge clk);
    chk("s_sticky", 32'(s_starve), 1);
    chk("s_main", 32'(starve), 0);
    chk("ops_1", 32'(host_ops), 1);
    step();

    // reset while a read sits in RDWAIT
    host_valid = 1'b1;
    host_we = 1'b0;
    host_addr = 12'h020;
    @(negedge clk);
    step();
    host_valid = 1'b0;
    @(negedge clk);
    chk("x_iss_en", 32'(mem_en), 1);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("x_rvalid", 32'(host_rvalid), 0);
    chk("x_ready", 32'(host_ready), 1);
    chk("x_ops", 32'(host_ops), 0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("x_rv_after", 32'(host_rvalid), 0);
    chk("x_en_after", 32'(mem_en), 0);
    step();

    // reset while a write is pending
    disp_req = 1'b1;
    disp_addr = 12'h000;
    host_valid = 1'b1;
    host_we = 1'b1;
    host_addr = 12'h030;
    host_wdata = 12'h555;
    @(negedge clk);
    step();
    host_valid = 1'b0;
    disp_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("p_rst_en", 32'(mem_en), 0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("p_en", 32'(mem_en), 0);
    chk("p_we", 32'(mem_we), 0);
    chk("p_ready", 32'(host_ready), 1);
    step();

    // host_ops wrap from the top of its range
    force dut.host_ops = 16'hFFFE;
    #2;
    release dut.host_ops;
    host_valid = 1'b1;
    host_we = 1'b1;
    host_addr = 12'h040;
    host_wdata = 12'h001;
    step();
    host_valid = 1'b0;
    @(negedge clk);
    chk("wr_iss_we", 32'(mem_we), 1);
    step();
    @(negedge clk);
    chk("ops_ffff", 32'(host_ops), 32'hFFFF);
    step();
    host_valid = 1'b1;
    step();
    host_valid = 1'b0;
    step();
    @(negedge clk);
    chk("ops_wrap", 32'(host_ops), 0);
    step();

    chk("dq_empty", 32'(dq.size()), 0);
    chk("hq_empty", 32'(hq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
